// File: rtl/rv_decode_stage.sv
// One-stage registered RV32I/RV32E decoder with valid/ready handshakes and flush.
// Define DEC_RV32M_EN to accept M-extension encodings (funct7 = 0000001 on the OP opcode).
module rv_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     INSTR,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [4:0]      RS1,
  output logic [4:0]      RS2,
  output logic [4:0]      RD,
  output logic [2:0]      FUNCT3,
  output logic [3:0]      ALU_OP,
  output logic            ALU_SRC,
  output logic [XLEN-1:0] IMM,
  output logic [3:0]      OPCLASS,
  output logic            REG_WE,
  output logic            ILLEGAL,
  output logic            MULDIV
);

  typedef enum logic [3:0] {
    ClsAluR   = 4'd0,
    ClsAluI   = 4'd1,
    ClsLoad   = 4'd2,
    ClsStore  = 4'd3,
    ClsBranch = 4'd4,
    ClsJal    = 4'd5,
    ClsJalr   = 4'd6,
    ClsLui    = 4'd7,
    ClsAuipc  = 4'd8,
    ClsNone   = 4'd15
  } opclass_e;

  localparam logic [6:0] OpAluR   = 7'b0110011;
  localparam logic [6:0] OpAluI   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_f, rs2_f, rd_f;

  assign opcode = INSTR[6:0];
  assign funct3 = INSTR[14:12];
  assign funct7 = INSTR[31:25];
  assign rs1_f  = INSTR[19:15];
  assign rs2_f  = INSTR[24:20];
  assign rd_f   = INSTR[11:7];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{INSTR[31]}}, INSTR[31:20]};
  assign imm_s = {{20{INSTR[31]}}, INSTR[31:25], INSTR[11:7]};
  assign imm_b = {{19{INSTR[31]}}, INSTR[31], INSTR[7], INSTR[30:25], INSTR[11:8], 1'b0};
  assign imm_u = {INSTR[31:12], 12'b0};
  assign imm_j = {{11{INSTR[31]}}, INSTR[31], INSTR[19:12], INSTR[20], INSTR[30:21], 1'b0};

  // Next-state decode of the word currently offered on INSTR.
  opclass_e        cls_d;
  logic [3:0]      alu_op_d;
  logic            alu_src_d;
  logic [31:0]     imm32_d;
  logic [XLEN-1:0] imm_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic            writes_rd;
  logic            reg_we_d;
  logic            illegal_d;
  logic            muldiv_d;
  logic            use_rs1, use_rs2, use_rd;
  logic            bad_enc;
  logic            bad_reg;

  always_comb begin
    cls_d     = ClsNone;
    alu_op_d  = 4'b0000;
    alu_src_d = 1'b1;
    imm32_d   = 32'd0;
    rs1_d     = rs1_f;
    rs2_d     = rs2_f;
    rd_d      = rd_f;
    writes_rd = 1'b0;
    muldiv_d  = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    bad_enc   = 1'b0;

    case (opcode)
      OpAluR: begin
        cls_d     = ClsAluR;
        alu_src_d = 1'b0;
        alu_op_d  = {INSTR[30], funct3};
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        use_rd    = 1'b1;
        if (funct7 == 7'b0000000) begin
          bad_enc = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          bad_enc = !((funct3 == 3'b000) || (funct3 == 3'b101));
`ifdef DEC_RV32M_EN
        end else if (funct7 == 7'b0000001) begin
          // INSTR[30] is 0 here, so alu_op already reads {0, funct3}.
          muldiv_d = 1'b1;
`endif
        end else begin
          bad_enc = 1'b1;
        end
      end
      OpAluI: begin
        cls_d     = ClsAluI;
        imm32_d   = imm_i;
        rs2_d     = 5'd0;
        alu_op_d  = {(funct3 == 3'b101) & INSTR[30], funct3};
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        if (funct3 == 3'b001) begin
          bad_enc = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          bad_enc = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      OpLoad: begin
        cls_d     = ClsLoad;
        imm32_d   = imm_i;
        rs2_d     = 5'd0;
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        bad_enc   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OpStore: begin
        cls_d   = ClsStore;
        imm32_d = imm_s;
        rd_d    = 5'd0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        bad_enc = (funct3 >= 3'b011);
      end
      OpBranch: begin
        cls_d     = ClsBranch;
        imm32_d   = imm_b;
        rd_d      = 5'd0;
        alu_op_d  = 4'b1000;
        alu_src_d = 1'b0;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        bad_enc   = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OpJal: begin
        cls_d     = ClsJal;
        imm32_d   = imm_j;
        rs1_d     = 5'd0;
        rs2_d     = 5'd0;
        writes_rd = 1'b1;
        use_rd    = 1'b1;
      end
      OpJalr: begin
        cls_d     = ClsJalr;
        imm32_d   = imm_i;
        rs2_d     = 5'd0;
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        bad_enc   = (funct3 != 3'b000);
      end
      OpLui, OpAuipc: begin
        cls_d     = (opcode == OpLui) ? ClsLui : ClsAuipc;
        imm32_d   = imm_u;
        rs1_d     = 5'd0;
        rs2_d     = 5'd0;
        writes_rd = 1'b1;
        use_rd    = 1'b1;
      end
      default: begin
        bad_enc = 1'b1;
      end
    endcase

    if (INSTR[1:0] != 2'b11) begin
      bad_enc = 1'b1;
    end

    bad_reg = (use_rs1 && ({27'd0, rs1_f} >= NREGS)) ||
              (use_rs2 && ({27'd0, rs2_f} >= NREGS)) ||
              (use_rd  && ({27'd0, rd_f}  >= NREGS));

    illegal_d = bad_enc || bad_reg;
    reg_we_d  = writes_rd && (rd_f != 5'd0);

    // Illegal words still travel down the pipe, but with neutral control so nothing executes.
    if (illegal_d) begin
      cls_d     = ClsNone;
      alu_op_d  = 4'b0000;
      alu_src_d = 1'b0;
      imm32_d   = 32'd0;
      reg_we_d  = 1'b0;
      muldiv_d  = 1'b0;
    end

    imm_d = XLEN'($signed(imm32_d));
  end

  // Pipeline register.
  logic            valid_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [2:0]      funct3_q;
  logic [3:0]      alu_op_q;
  logic            alu_src_q;
  logic [XLEN-1:0] imm_q;
  opclass_e        cls_q;
  logic            reg_we_q;
  logic            illegal_q;
  logic            load;

  assign IN_READY = !valid_q || OUT_READY;
  assign load     = IN_VALID && IN_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q   <= 1'b0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
      funct3_q  <= 3'd0;
      alu_op_q  <= 4'd0;
      alu_src_q <= 1'b0;
      imm_q     <= '0;
      cls_q     <= ClsNone;
      reg_we_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (FLUSH) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q   <= 1'b1;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      funct3_q  <= funct3;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      imm_q     <= imm_d;
      cls_q     <= cls_d;
      reg_we_q  <= reg_we_d;
      illegal_q <= illegal_d;
    end else if (OUT_READY) begin
      valid_q <= 1'b0;
    end
  end

`ifdef DEC_RV32M_EN
  logic muldiv_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      muldiv_q <= 1'b0;
    end else if (!FLUSH && load) begin
      muldiv_q <= muldiv_d;
    end
  end

  assign MULDIV = muldiv_q;
`else
  assign MULDIV = 1'b0;
`endif

  assign OUT_VALID = valid_q;
  assign RS1       = rs1_q;
  assign RS2       = rs2_q;
  assign RD        = rd_q;
  assign FUNCT3    = funct3_q;
  assign ALU_OP    = alu_op_q;
  assign ALU_SRC   = alu_src_q;
  assign IMM       = imm_q;
  assign OPCLASS   = cls_q;
  assign REG_WE    = reg_we_q;
  assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed-vector bench for rv_decode_stage; a second instance runs with NREGS=16 (RV32E).
module tb_rv_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;

  logic        in_ready, out_valid, alu_src, reg_we, illegal, muldiv;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [3:0]  alu_op, opclass;
  logic [31:0] imm;

  logic        e_in_ready, e_out_valid, e_alu_src, e_reg_we, e_illegal, e_muldiv;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [2:0]  e_funct3;
  logic [3:0]  e_alu_op, e_opclass;
  logic [31:0] e_imm;

  int checks = 0;
  int errors = 0;

  rv_decode_stage #(.XLEN(32), .NREGS(32)) u_dut (
    .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(in_ready),
    .INSTR(instr), .OUT_VALID(out_valid), .OUT_READY(out_ready), .RS1(rs1), .RS2(rs2),
    .RD(rd), .FUNCT3(funct3), .ALU_OP(alu_op), .ALU_SRC(alu_src), .IMM(imm),
    .OPCLASS(opclass), .REG_WE(reg_we), .ILLEGAL(illegal), .MULDIV(muldiv)
  );

  rv_decode_stage #(.XLEN(32), .NREGS(16)) u_dut_e (
    .CLK(clk), .RST(rst), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(e_in_ready),
    .INSTR(instr), .OUT_VALID(e_out_valid), .OUT_READY(out_ready), .RS1(e_rs1), .RS2(e_rs2),
    .RD(e_rd), .FUNCT3(e_funct3), .ALU_OP(e_alu_op), .ALU_SRC(e_alu_src), .IMM(e_imm),
    .OPCLASS(e_opclass), .REG_WE(e_reg_we), .ILLEGAL(e_illegal), .MULDIV(e_muldiv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] word);
    in_valid = 1'b1;
    instr    = word;
    step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"}, out_valid, 1'b0);
    check({tag, ".opclass"}, opclass, 4'd15);
    check({tag, ".imm"}, imm, 32'h0);
    check({tag, ".rd"}, rd, 5'd0);
    check({tag, ".rs1"}, rs1, 5'd0);
    check({tag, ".reg_we"}, reg_we, 1'b0);
    check({tag, ".alu_op"}, alu_op, 4'd0);
  endtask

  task automatic check_illegal(input string tag);
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".illegal"}, illegal, 1'b1);
    check({tag, ".reg_we"}, reg_we, 1'b0);
    check({tag, ".opclass"}, opclass, 4'd15);
    check({tag, ".imm"}, imm, 32'h0);
    check({tag, ".alu_op"}, alu_op, 4'd0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'h0;
    out_ready = 1'b1;
    step();
    step();
    check_reset("reset");
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.e_valid", e_out_valid, 1'b0);
    rst = 1'b0;

    // addi x1, x0, -1
    offer(32'hFFF00093);
    check("addi.valid", out_valid, 1'b1);
    check("addi.rd", rd, 5'd1);
    check("addi.rs1", rs1, 5'd0);
    check("addi.rs2", rs2, 5'd0);
    check("addi.imm", imm, 32'hFFFFFFFF);
    check("addi.alu_op", alu_op, 4'b0000);
    check("addi.alu_src", alu_src, 1'b1);
    check("addi.opclass", opclass, 4'd1);
    check("addi.reg_we", reg_we, 1'b1);
    check("addi.illegal", illegal, 1'b0);

    // sub x3, x1, x2 followed immediately by srai x5, x6, 3
    offer(32'h402081B3);
    check("sub.valid", out_valid, 1'b1);
    check("sub.in_ready", in_ready, 1'b1);
    check("sub.alu_op", alu_op, 4'b1000);
    check("sub.alu_src", alu_src, 1'b0);
    check("sub.rs1", rs1, 5'd1);
    check("sub.rs2", rs2, 5'd2);
    check("sub.rd", rd, 5'd3);
    check("sub.opclass", opclass, 4'd0);
    check("sub.imm", imm, 32'h0);
    check("sub.reg_we", reg_we, 1'b1);
    offer(32'h40335293);
    check("srai.valid", out_valid, 1'b1);
    check("srai.alu_op", alu_op, 4'b1101);
    check("srai.imm", imm, 32'h00000403);
    check("srai.rd", rd, 5'd5);
    check("srai.rs1", rs1, 5'd6);
    check("srai.rs2", rs2, 5'd0);
    check("srai.illegal", illegal, 1'b0);

    // sw x2, 8(x1)
    offer(32'h0020A423);
    check("sw.imm", imm, 32'h8);
    check("sw.opclass", opclass, 4'd3);
    check("sw.reg_we", reg_we, 1'b0);
    check("sw.rd", rd, 5'd0);
    check("sw.rs2", rs2, 5'd2);
    check("sw.funct3", funct3, 3'b010);

    // beq x1, x2, -4, then stall it for 3 cycles with a new word pending
    offer(32'hFE208EE3);
    check("beq.imm", imm, 32'hFFFFFFFC);
    check("beq.alu_op", alu_op, 4'b1000);
    check("beq.opclass", opclass, 4'd4);
    check("beq.alu_src", alu_src, 1'b0);
    check("beq.reg_we", reg_we, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h00208A33;
    #1;
    check("stall.in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.valid", out_valid, 1'b1);
      check("stall.in_ready", in_ready, 1'b0);
      check("stall.imm", imm, 32'hFFFFFFFC);
      check("stall.opclass", opclass, 4'd4);
      check("stall.rs1", rs1, 5'd1);
      check("stall.rd", rd, 5'd0);
    end

    // Flush while stalled, then flush again while the stage is ready and a word is offered.
    flush = 1'b1;
    step();
    check("flush.valid", out_valid, 1'b0);
    check("flush.in_ready", in_ready, 1'b1);
    instr = 32'hFFF00093;
    step();
    check("flush_drop.valid", out_valid, 1'b0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    check("flush_idle.valid", out_valid, 1'b0);

    // Reset during a stall, with a word still offered.
    out_ready = 1'b1;
    offer(32'hFFF00093);
    out_ready = 1'b0;
    instr = 32'h402081B3;
    step();
    check("prereset.valid", out_valid, 1'b1);
    rst = 1'b1;
    step();
    check_reset("midreset");
    rst = 1'b0;
    out_ready = 1'b1;

    // Illegal all-zero word
    offer(32'h00000000);
    check_illegal("zero");

    // add x20, x1, x2: legal for RV32I, illegal for RV32E
    offer(32'h00208A33);
    check("add20.illegal", illegal, 1'b0);
    check("add20.rd", rd, 5'd20);
    check("add20.reg_we", reg_we, 1'b1);
    check("add20.opclass", opclass, 4'd0);
    check("add20e.valid", e_out_valid, 1'b1);
    check("add20e.illegal", e_illegal, 1'b1);
    check("add20e.reg_we", e_reg_we, 1'b0);
    check("add20e.opclass", e_opclass, 4'd15);

    // lw x1, 0(x1) legal; the same with funct3 = 011 is illegal
    offer(32'h0000A083);
    check("lw.opclass", opclass, 4'd2);
    check("lw.reg_we", reg_we, 1'b1);
    check("lw.illegal", illegal, 1'b0);
    check("lw.e_illegal", e_illegal, 1'b0);
    offer(32'h0000B083);
    check_illegal("ld");

    // slli with funct7 = 0100000 is illegal
    offer(32'h40109093);
    check_illegal("slli_bad");

    // addi x0, x0, 0 must not write
    offer(32'h00000013);
    check("nop.reg_we", reg_we, 1'b0);
    check("nop.illegal", illegal, 1'b0);
    check("nop.opclass", opclass, 4'd1);

    // lui x5, 0x12345
    offer(32'h123452B7);
    check("lui.imm", imm, 32'h12345000);
    check("lui.opclass", opclass, 4'd7);
    check("lui.rs1", rs1, 5'd0);
    check("lui.reg_we", reg_we, 1'b1);
    check("lui.alu_src", alu_src, 1'b1);

    // jal x1, +8
    offer(32'h008000EF);
    check("jal.imm", imm, 32'h8);
    check("jal.opclass", opclass, 4'd5);
    check("jal.rd", rd, 5'd1);
    check("jal.reg_we", reg_we, 1'b1);

    // mul x1, x2, x3
    offer(32'h023100B3);
`ifdef DEC_RV32M_EN
    check("mul.illegal", illegal, 1'b0);
    check("mul.muldiv", muldiv, 1'b1);
    check("mul.alu_op", alu_op, 4'b0000);
    check("mul.opclass", opclass, 4'd0);
    check("mul.reg_we", reg_we, 1'b1);
`else
    check("mul.illegal", illegal, 1'b1);
    check("mul.muldiv", muldiv, 1'b0);
    check("mul.opclass", opclass, 4'd15);
    check("mul.reg_we", reg_we, 1'b0);
`endif

    // Downstream drains: valid drops when nothing new is offered.
    in_valid = 1'b0;
    step();
    check("drain.valid", out_valid, 1'b0);
    check("drain.e_valid", e_out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
